// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encodings, the
// resolved control-flow decision, default widths/depths and the
// ret > call > jump priority decode.
package fetch_sequencer_pkg;

   localparam int INSTR_WORD_WIDTH = 8;
   localparam int INSTR_DATA_WIDTH = 8;
   localparam int RSTACK_DEPTH     = 4;

   typedef enum logic [2:0] {
      FS_IDLE   = 3'd0,
      FS_REQ    = 3'd1,
      FS_ISSUE  = 3'd2,
      FS_UPDATE = 3'd3,
      FS_HALTED = 3'd4
   } fs_state_t;

   typedef enum logic [1:0] {
      DEC_SEQ  = 2'd0,
      DEC_JUMP = 2'd1,
      DEC_CALL = 2'd2,
      DEC_RET  = 2'd3
   } fs_decision_t;

   function automatic fs_decision_t decode_flow(input logic jump, input logic call,
                                                input logic ret);
      if (ret)
         return DEC_RET;
      else if (call)
         return DEC_CALL;
      else if (jump)
         return DEC_JUMP;
      else
         return DEC_SEQ;
   endfunction

endpackage

// File: rtl/fetch_sequencer_ret_stack.sv
// Return-address LIFO for the fetch sequencer.
// Ports:
//   clk, rst        clock / async active-low reset (clears pointer and contents)
//   push, push_data write push_data on top (ignored when full)
//   pop             discard top entry (ignored when empty)
//   top             current top entry (meaningless when empty)
//   full, empty     occupancy flags
// The FSM never asserts push and pop together.
module fetch_sequencer_ret_stack
   import fetch_sequencer_pkg::*;
#(
   parameter int WIDTH = INSTR_WORD_WIDTH,
   parameter int DEPTH = RSTACK_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // sp counts occupied entries, so it needs one bit more than the index.
   logic [AW:0]      sp;
   logic [AW:0]      sp_m1;
   logic [WIDTH-1:0] mem [DEPTH];

   assign sp_m1 = sp - 1'b1;
   assign full  = (sp == (AW+1)'(DEPTH));
   assign empty = (sp == '0);
   assign top   = mem[sp_m1[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (push && !full) begin
         mem[sp[AW-1:0]] <= push_data;
         sp              <= sp + 1'b1;
      end else if (pop && !empty) begin
         sp <= sp - 1'b1;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: control side of the program counter. Fetches the word at
// pc_value over a req/ack memory port, presents it to the core over
// valid/ready, then updates the counter (increment, load target, or load a
// popped return address) for one cycle before the next fetch.
// Ports:
//   clk, rst                 clock / async active-low reset
//   run, halt                fetch enable level / stop request sampled at retire
//   pc_value                 current counter value (fetch address)
//   pc_we, pc_en, pc_data_in counter load / increment / load value
//   mem_req, mem_addr        program memory request and address
//   mem_ack, mem_data        program memory response
//   instr, instr_valid       instruction word to the core
//   instr_ready              core accepts instr; qualifies jump/call/ret/target
//   jump, call, ret, target  control-flow request from the core
//   stack_err                sticky return-stack overflow/underflow
//   busy                     not in IDLE or HALTED
//
// state     | meaning
// ----------+---------------------------------------------------------
// FS_IDLE   | waiting for run (halt wins)
// FS_REQ    | memory request at pc_value until ack, word captured
// FS_ISSUE  | word presented to core until ready, decision captured
// FS_UPDATE | one-cycle counter update and stack push/pop
// FS_HALTED | stopped; only reset leaves
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int WIDTH = INSTR_WORD_WIDTH,
   parameter int IW    = INSTR_DATA_WIDTH,
   parameter int DEPTH = RSTACK_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             halt,
   input  logic [WIDTH-1:0] pc_value,
   output logic             pc_we,
   output logic             pc_en,
   output logic [WIDTH-1:0] pc_data_in,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_ack,
   input  logic [IW-1:0]    mem_data,
   output logic [IW-1:0]    instr,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic             jump,
   input  logic             call,
   input  logic             ret,
   input  logic [WIDTH-1:0] target,
   output logic             stack_err,
   output logic             busy
);

   fs_state_t        state, state_nxt;
   fs_decision_t     dec_q;
   logic [IW-1:0]    instr_q;
   logic [WIDTH-1:0] target_q;
   logic             err_q;

   logic             push, pop, full, empty;
   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] ret_addr;

   // In UPDATE the counter still holds the address of the retiring
   // instruction, so the return address is simply the next one (wraps).
   assign ret_addr = pc_value + WIDTH'(1);

   fetch_sequencer_ret_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (ret_addr),
      .top       (top),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FS_IDLE;
         dec_q    <= DEC_SEQ;
         instr_q  <= '0;
         target_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == FS_REQ && mem_ack)
            instr_q <= mem_data;
         if (state == FS_ISSUE && instr_ready) begin
            dec_q    <= decode_flow(jump, call, ret);
            target_q <= target;
         end
         if (state == FS_UPDATE &&
             ((dec_q == DEC_CALL && full) || (dec_q == DEC_RET && empty)))
            err_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      mem_req     = 1'b0;
      mem_addr    = '0;
      instr       = '0;
      instr_valid = 1'b0;
      pc_we       = 1'b0;
      pc_en       = 1'b0;
      pc_data_in  = '0;
      push        = 1'b0;
      pop         = 1'b0;
      case (state)
         FS_IDLE: begin
            if (halt)
               state_nxt = FS_HALTED;
            else if (run)
               state_nxt = FS_REQ;
         end
         FS_REQ: begin
            mem_req  = 1'b1;
            mem_addr = pc_value;
            if (mem_ack)
               state_nxt = FS_ISSUE;
         end
         FS_ISSUE: begin
            instr_valid = 1'b1;
            instr       = instr_q;
            if (instr_ready)
               state_nxt = FS_UPDATE;
         end
         FS_UPDATE: begin
            case (dec_q)
               DEC_SEQ: pc_en = 1'b1;
               DEC_JUMP: begin
                  pc_we      = 1'b1;
                  pc_data_in = target_q;
               end
               DEC_CALL: begin
                  // A full stack drops the push but the jump is still taken.
                  push       = !full;
                  pc_we      = 1'b1;
                  pc_data_in = target_q;
               end
               DEC_RET: begin
                  // Underflow degrades to a sequential step.
                  if (!empty) begin
                     pop        = 1'b1;
                     pc_we      = 1'b1;
                     pc_data_in = top;
                  end else begin
                     pc_en = 1'b1;
                  end
               end
               default: pc_en = 1'b1;
            endcase
            if (halt)
               state_nxt = FS_HALTED;
            else if (run)
               state_nxt = FS_REQ;
            else
               state_nxt = FS_IDLE;
         end
         FS_HALTED: state_nxt = FS_HALTED;
         default:   state_nxt = FS_IDLE;
      endcase
   end

   assign stack_err = err_q;
   assign busy      = (state != FS_IDLE) && (state != FS_HALTED);

endmodule
